// File: rtl/sfgen_arith_pkg.sv
// Shared arithmetic definitions for generated datapath leaves.
// Latency: none (types and constants only).
// Backpressure: not applicable.
//
// Contents:
//   tc16_t    16-bit two's-complement word
//   TC16_MIN  most-negative 16-bit value (no positive counterpart)
//   TC16_MAX  most-positive 16-bit value
package sfgen_arith_pkg;

  typedef logic [15:0] tc16_t;

  localparam tc16_t TC16_MIN = 16'h8000;
  localparam tc16_t TC16_MAX = 16'h7FFF;

  // True for the single input whose magnitude is not representable.
  function automatic logic is_tc16_min(input tc16_t v);
    return (v == TC16_MIN);
  endfunction

endpackage

// File: rtl/tc_negate_16.sv
// Combinational 16-bit two's-complement negate (~a + 1, modulo 2^16).
// Latency: zero, purely combinational.
// Backpressure: none.
//
// Ports:
//   a    operand
//   neg  -a modulo 2^16 (0x8000 maps to itself)
module tc_negate_16
  import sfgen_arith_pkg::*;
(
  input  tc16_t a,
  output tc16_t neg
);

  assign neg = ~a + 16'd1;

endmodule

// File: rtl/tc_abs_16_unit.sv
// Absolute value of a 16-bit signed operand, combinational plus registered copy.
// Latency: fs_0/ovf zero cycles; fs_0_q/ovf_q/out_valid one cycle.
// Backpressure: none, an operand is accepted every cycle.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (registered path only)
//   a            signed operand
//   in_valid     qualifies a for capture into the registered path
//   fs_0, ovf    combinational |a| and most-negative flag
//   fs_0_q       registered |a|, holds while in_valid is low
//   ovf_q        registered ovf, holds while in_valid is low
//   out_valid    in_valid delayed by one cycle
module tc_abs_16_unit
  import sfgen_arith_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic [WIDTH-1:0] fs_0,
  output logic             ovf,
  output logic [WIDTH-1:0] fs_0_q,
  output logic             out_valid,
  output logic             ovf_q
);

  tc16_t neg_a;
  tc16_t mag;
  logic  is_min;

  tc_negate_16 u_negate (
    .a   (a),
    .neg (neg_a)
  );

  // Sign-select between operand and its negation; 0x8000 negates to itself,
  // which is exactly the wrap behaviour.
  assign mag    = a[WIDTH-1] ? neg_a : a;
  assign is_min = is_tc16_min(a);

  assign ovf  = is_min;
  assign fs_0 = (SATURATE && is_min) ? TC16_MAX : mag;

  // Result/flag only load on a valid operand so the last good result stays
  // visible; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_0_q    <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        fs_0_q <= fs_0;
        ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_tc_abs_16_unit.sv
module tb_tc_abs_16_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        in_valid;

  logic [15:0] w_fs, w_fsq, s_fs, s_fsq;
  logic        w_ovf, w_ovfq, w_vld, s_ovf, s_ovfq, s_vld;

  int tests = 0;
  int fails = 0;

  tc_abs_16_unit #(.WIDTH(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid),
    .fs_0(w_fs), .ovf(w_ovf), .fs_0_q(w_fsq), .out_valid(w_vld), .ovf_q(w_ovfq)
  );

  tc_abs_16_unit #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid),
    .fs_0(s_fs), .ovf(s_ovf), .fs_0_q(s_fsq), .out_valid(s_vld), .ovf_q(s_ovfq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_abs(input logic [15:0] x, input bit sat);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v == 32768) return sat ? 16'h7FFF : 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x);
    return ($signed(x) == -32768);
  endfunction

  logic [15:0] m_q0, m_q1;
  logic        m_ovf, m_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q0 = 16'h0; m_q1 = 16'h0; m_ovf = 1'b0; m_vld = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_q0  = ref_abs(a, 1'b0);
        m_q1  = ref_abs(a, 1'b1);
        m_ovf = ref_ovf(a);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_fs_wrap",  w_fs,  ref_abs(a, 1'b0));
    chk("cyc_fs_sat",   s_fs,  ref_abs(a, 1'b1));
    chk("cyc_ovf_wrap", {15'd0, w_ovf}, {15'd0, ref_ovf(a)});
    chk("cyc_ovf_sat",  {15'd0, s_ovf}, {15'd0, ref_ovf(a)});
    chk("cyc_q_wrap",   w_fsq, m_q0);
    chk("cyc_q_sat",    s_fsq, m_q1);
    chk("cyc_ovfq",     {14'd0, w_ovfq, s_ovfq}, {14'd0, m_ovf, m_ovf});
    chk("cyc_vld",      {14'd0, w_vld, s_vld},   {14'd0, m_vld, m_vld});
  end

  task automatic drive(input logic [15:0] v, input logic vld);
    @(posedge clk);
    #1;
    a = v;
    in_valid = vld;
  endtask

  // Combinational literal check for both instances.
  task automatic comb(input logic [15:0] v, input logic [15:0] exp_w,
                      input logic [15:0] exp_s, input logic exp_o);
    a = v;
    #1;
    chk("lit_fs_wrap", w_fs, exp_w);
    chk("lit_fs_sat",  s_fs, exp_s);
    chk("lit_ovf",     {14'd0, w_ovf, s_ovf}, {14'd0, exp_o, exp_o});
  endtask

  logic [15:0] stream_in  [4];
  logic [15:0] stream_exp [4];
  logic [15:0] r;

  initial begin
    rst_n = 1'b0;
    a = 16'h0;
    in_valid = 1'b0;
    #1;
    chk("rst_q",   w_fsq | s_fsq, 16'h0);
    chk("rst_vld", {14'd0, w_vld, s_vld}, 16'h0);
    chk("rst_ovfq", {14'd0, w_ovfq, s_ovfq}, 16'h0);
    #12;
    rst_n = 1'b1;

    // Directed combinational values (between edges).
    @(posedge clk); #1;
    comb(16'h0001, 16'h0001, 16'h0001, 1'b0);
    comb(16'hFF16, 16'h00EA, 16'h00EA, 1'b0);
    comb(16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    comb(16'h0000, 16'h0000, 16'h0000, 1'b0);
    comb(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    comb(16'h8001, 16'h7FFF, 16'h7FFF, 1'b0);
    comb(16'h8000, 16'h8000, 16'h7FFF, 1'b1);

    // One-cycle capture of 0x0001, then 0x8000 with overflow.
    drive(16'h0001, 1'b1);
    @(posedge clk); #1;
    chk("cap1_q",   w_fsq, 16'h0001);
    chk("cap1_vld", {15'd0, w_vld}, 16'h0001);
    a = 16'h8000;
    @(posedge clk); #1;
    chk("min_q_wrap", w_fsq, 16'h8000);
    chk("min_q_sat",  s_fsq, 16'h7FFF);
    chk("min_ovfq",   {14'd0, w_ovfq, s_ovfq}, 16'h0003);

    // Pipeline stream 5, -5, 300, -300 then idle.
    stream_in[0] = 16'd5;   stream_in[1] = 16'hFFFB;
    stream_in[2] = 16'd300; stream_in[3] = 16'hFED4;
    stream_exp[0] = 16'd5;   stream_exp[1] = 16'd5;
    stream_exp[2] = 16'd300; stream_exp[3] = 16'd300;
    a = stream_in[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stream_q", w_fsq, stream_exp[i]);
      chk("stream_vld", {15'd0, w_vld}, 16'h0001);
      if (i < 3) a = stream_in[i+1];
      else begin a = 16'h1234; in_valid = 1'b0; end
    end
    @(posedge clk); #1;
    chk("idle_vld",  {15'd0, w_vld}, 16'h0000);
    chk("idle_hold", w_fsq, 16'h012C);
    chk("idle_ovfq", {15'd0, w_ovfq}, 16'h0000);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q",   w_fsq | s_fsq, 16'h0000);
    chk("arst_vld", {14'd0, w_vld, s_vld}, 16'h0000);
    a = 16'hFF16;
    #1;
    chk("arst_comb", w_fs, 16'h00EA);
    @(negedge clk); #1;
    rst_n = 1'b1;
    a = 16'h0123;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_q",   w_fsq, 16'h0123);
    chk("post_rst_vld", {15'd0, w_vld}, 16'h0001);

    // Randomized sweep; checked each cycle by the compare process.
    for (int i = 0; i < 10000; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 15))
        0: r = 16'h8000;
        1: r = 16'h7FFF;
        2: r = 16'h8001;
        3: r = 16'h0000;
        default: ;
      endcase
      drive(r, 1'($urandom_range(0, 3) != 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
